alarm_responder: RTL and testbench



---
 rtl/alarm_pkg.sv | 19 +
 rtl/alarm_responder_code_entry.sv | 47 ++++
 rtl/alarm_responder.sv | 88 ++++++++
 tb/tb_alarm_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encodings and keypad constants for the alarm subsystem
package alarm_pkg;
    typedef enum logic [1:0] {
        OFF       = 2'd0,
        ARMED     = 2'd1,
        TRIGGERED = 2'd2,
        ALARM_ON  = 2'd3
    } sec_state_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SOUNDING = 3'd1,
        ENTRY    = 3'd2,
        LOCKOUT  = 3'd3,
        CLEARING = 3'd4
    } resp_state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hF;
endpackage

// File: rtl/alarm_responder_code_entry.sv
// code_entry: keypad digit buffer with inter-key timeout and 4-digit code compare
module code_entry
    import alarm_pkg::*;
#(
    parameter logic [15:0] CODE          = 16'h1234,
    parameter int          ENTRY_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       active,
    input  logic       key_valid,
    input  logic [3:0] key_data,
    output logic       match,
    output logic       mismatch,
    output logic       abandon
);
    localparam int TW = $clog2(ENTRY_TIMEOUT + 1);
    logic [11:0]   digits;
    logic [1:0]    digit_cnt;
    logic [TW-1:0] timer;
    logic          key, clear_key, last, expired;

    always_comb begin
        key       = active && key_valid;
        clear_key = key && key_data == KEY_CLEAR;
        last      = key && !clear_key && digit_cnt == 2'd3;
        expired   = active && !key_valid && timer == TW'(ENTRY_TIMEOUT - 1);
        match     = last && {digits, key_data} == CODE;
        mismatch  = last && {digits, key_data} != CODE;
        abandon   = clear_key || expired;
    end

    always_ff @(posedge clk) begin
        if (rst || (!active && !load) || clear_key || last || expired) begin
            digits    <= '0;
            digit_cnt <= '0;
            timer     <= '0;
        end else if (load || key) begin
            digits    <= {digits[7:0], key_data};
            digit_cnt <= digit_cnt + 2'd1;
            timer     <= '0;
        end else begin
            timer     <= timer + 1'b1;
        end
    end
endmodule

// File: rtl/alarm_responder.sv
// alarm_responder: siren cadence, keypad disarm, wrong-code lockout beside the alarm FSM
module alarm_responder
    import alarm_pkg::*;
#(
    parameter logic [15:0] CODE          = 16'h1234,
    parameter int          SIREN_ON_CYC  = 8,
    parameter int          SIREN_OFF_CYC = 8,
    parameter int          MAX_TRIES     = 3,
    parameter int          LOCKOUT_CYC   = 64,
    parameter int          ENTRY_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alarm_in,
    input  logic       key_valid,
    input  logic [3:0] key_data,
    output logic       siren,
    output logic       disarm,
    output logic       locked,
    output logic       entry_active,
    output logic [1:0] fail_cnt,
    output logic [2:0] resp_state
);
    localparam int PERIOD = SIREN_ON_CYC + SIREN_OFF_CYC;
    localparam int CW     = $clog2(PERIOD + 1);
    localparam int LW     = $clog2(LOCKOUT_CYC + 1);

    resp_state_t   state, nxt;
    logic [CW-1:0] cad;
    logic [LW-1:0] lock_cnt;
    logic [1:0]    fails, fail_next;
    logic          load, active, match, mismatch, abandon, lock_done, sounding;

    assign load      = state == SOUNDING && alarm_in && key_valid && key_data != KEY_CLEAR;
    assign active    = state == ENTRY && alarm_in;
    assign fail_next = fails + 2'd1;
    assign lock_done = lock_cnt == LW'(LOCKOUT_CYC - 1);
    assign sounding  = state == SOUNDING || state == ENTRY;

    code_entry #(.CODE(CODE), .ENTRY_TIMEOUT(ENTRY_TIMEOUT)) u_entry (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .active   (active),
        .key_valid(key_valid),
        .key_data (key_data),
        .match    (match),
        .mismatch (mismatch),
        .abandon  (abandon)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:     nxt = alarm_in ? SOUNDING : IDLE;
            SOUNDING: nxt = !alarm_in ? IDLE : load ? ENTRY : SOUNDING;
            ENTRY:    nxt = !alarm_in ? IDLE : match ? CLEARING :
                            mismatch ? (fail_next == 2'(MAX_TRIES) ? LOCKOUT : SOUNDING) :
                            abandon ? SOUNDING : ENTRY;
            LOCKOUT:  nxt = !alarm_in ? IDLE : lock_done ? SOUNDING : LOCKOUT;
            CLEARING: nxt = alarm_in ? CLEARING : IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // cadence runs only while sounding, so every other state re-enters SOUNDING at count 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cad      <= '0;
            lock_cnt <= '0;
            fails    <= '0;
        end else begin
            state    <= nxt;
            cad      <= sounding && cad != CW'(PERIOD - 1) ? cad + 1'b1 : '0;
            lock_cnt <= state == LOCKOUT && nxt == LOCKOUT ? lock_cnt + 1'b1 : '0;
            fails    <= nxt == IDLE || match || (state == LOCKOUT && nxt == SOUNDING) ? '0 :
                        mismatch ? fail_next : fails;
        end
    end

    assign siren        = state == LOCKOUT || (sounding && cad < CW'(SIREN_ON_CYC));
    assign disarm       = state == CLEARING;
    assign locked       = state == LOCKOUT;
    assign entry_active = state == ENTRY;
    assign fail_cnt     = fails;
    assign resp_state   = state;
endmodule

// File: tb/tb_alarm_responder.sv
// tb_alarm_responder: scoreboard bench comparing every cycle against a queue-based reference model
module tb_alarm_responder;
    localparam logic [15:0] CODE = 16'h1234;
    localparam int SIREN_ON_CYC  = 8;
    localparam int SIREN_OFF_CYC = 8;
    localparam int MAX_TRIES     = 3;
    localparam int LOCKOUT_CYC   = 64;
    localparam int ENTRY_TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1, alarm_in = 1'b0, key_valid = 1'b0;
    logic [3:0] key_data = 4'h0;
    logic       siren, disarm, locked, entry_active;
    logic [1:0] fail_cnt;
    logic [2:0] resp_state;

    alarm_responder #(
        .CODE(CODE), .SIREN_ON_CYC(SIREN_ON_CYC), .SIREN_OFF_CYC(SIREN_OFF_CYC),
        .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYC(LOCKOUT_CYC), .ENTRY_TIMEOUT(ENTRY_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .alarm_in(alarm_in), .key_valid(key_valid), .key_data(key_data),
        .siren(siren), .disarm(disarm), .locked(locked), .entry_active(entry_active),
        .fail_cnt(fail_cnt), .resp_state(resp_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       siren;
        logic       disarm;
        logic       locked;
        logic       entry;
        logic [1:0] fail;
        logic [2:0] st;
    } out_t;

    out_t exp_q[$];
    int   checks = 0, failures = 0, cyc = 0;

    // reference model: mode, entered digits, wrong tries, cycles since cadence start, idle and lockout time
    int m_st = 0, fail_m = 0, cad_m = 0, idle_m = 0, lock_m = 0;
    int digs[$];

    function automatic out_t expected();
        out_t o;
        o.siren  = m_st == 3 || ((m_st == 1 || m_st == 2) && (cad_m % (SIREN_ON_CYC + SIREN_OFF_CYC)) < SIREN_ON_CYC);
        o.disarm = m_st == 4;
        o.locked = m_st == 3;
        o.entry  = m_st == 2;
        o.fail   = 2'(fail_m);
        o.st     = 3'(m_st);
        return o;
    endfunction

    task automatic model_step(input logic r, input logic a, input logic kv, input logic [3:0] kd);
        int entered;
        if (r) begin
            m_st = 0; digs.delete(); fail_m = 0; cad_m = 0; idle_m = 0; lock_m = 0;
            return;
        end
        case (m_st)
            0: if (a) begin m_st = 1; cad_m = 0; end
            4: if (!a) m_st = 0;
            default:
                if (!a) begin
                    m_st = 0; digs.delete(); fail_m = 0;
                end else if (m_st == 3) begin
                    lock_m++;
                    if (lock_m == LOCKOUT_CYC) begin m_st = 1; fail_m = 0; cad_m = 0; end
                end else begin
                    cad_m++;
                    if (m_st == 1) begin
                        if (kv && kd != 4'hF) begin digs.push_back(int'(kd)); idle_m = 0; m_st = 2; end
                    end else if (kv && kd == 4'hF) begin
                        digs.delete(); m_st = 1;
                    end else if (kv) begin
                        digs.push_back(int'(kd)); idle_m = 0;
                        if (digs.size() == 4) begin
                            entered = digs[0] * 4096 + digs[1] * 256 + digs[2] * 16 + digs[3];
                            digs.delete();
                            if (entered == int'(CODE)) begin
                                m_st = 4; fail_m = 0;
                            end else begin
                                fail_m++;
                                if (fail_m == MAX_TRIES) begin m_st = 3; lock_m = 0; end
                                else m_st = 1;
                            end
                        end
                    end else begin
                        idle_m++;
                        if (idle_m == ENTRY_TIMEOUT) begin digs.delete(); m_st = 1; end
                    end
                end
        endcase
    endtask

    task automatic tick(input logic r, input logic a, input logic kv, input logic [3:0] kd);
        rst = r; alarm_in = a; key_valid = kv; key_data = kd;
        @(posedge clk);
        model_step(r, a, kv, kd);
        exp_q.push_back(expected());
        #1;
    endtask

    task automatic idle(input int n, input logic a);
        repeat (n) tick(1'b0, a, 1'b0, 4'h0);
    endtask

    task automatic press(input logic [3:0] d, input int gap);
        tick(1'b0, 1'b1, 1'b1, d);
        idle(gap - 1, 1'b1);
    endtask

    always @(negedge clk) begin
        out_t e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {siren, disarm, locked, entry_active, fail_cnt, resp_state};
            checks++;
            cyc++;
            if (g !== e)
                begin
                    failures++;
                    $display("FAIL outputs cycle %0d: got siren=%b disarm=%b locked=%b entry=%b fail_cnt=%0d state=%0d, expected siren=%b disarm=%b locked=%b entry=%b fail_cnt=%0d state=%0d",
                             cyc, g.siren, g.disarm, g.locked, g.entry, g.fail, g.st,
                             e.siren, e.disarm, e.locked, e.entry, e.fail, e.st);
                end
        end
    end

    initial begin
        int ci;
        logic r, a, kv;
        logic [3:0] kd;
        tick(1'b1, 1'b1, 1'b1, 4'h5);
        tick(1'b1, 1'b1, 1'b1, 4'h5);
        idle(49, 1'b1);
        press(4'h1, 5); press(4'h2, 5); press(4'h3, 5); press(4'h4, 1);
        idle(10, 1'b1);
        idle(3, 1'b0);
        idle(3, 1'b1);
        repeat (3) begin
            press(4'h9, 2); press(4'h9, 2); press(4'h9, 2); press(4'h9, 2);
        end
        repeat (58) tick(1'b0, 1'b1, 1'($urandom_range(1)), 4'($urandom_range(15)));
        idle(6, 1'b1);
        press(4'h1, 2); press(4'h2, 2); press(4'h3, 2); press(4'h4, 2);
        idle(3, 1'b1);
        idle(2, 1'b0);
        idle(2, 1'b1);
        press(4'h1, 2); press(4'h2, 1);
        idle(40, 1'b1);
        press(4'h1, 2); press(4'h2, 2); press(4'hF, 2);
        idle(5, 1'b1);
        press(4'h1, 2); press(4'h2, 2);
        tick(1'b0, 1'b0, 1'b1, 4'h3);
        idle(1, 1'b0);
        idle(2, 1'b1);
        press(4'h3, 2); press(4'h4, 1);
        idle(40, 1'b1);
        ci = 0;
        repeat (3000) begin
            r  = $urandom_range(999) == 0;
            a  = $urandom_range(299) != 0;
            kv = $urandom_range(3) == 0;
            kd = 4'($urandom_range(15));
            if (kv && $urandom_range(1) == 1) begin
                kd = 4'(CODE >> (12 - 4 * ci));
                ci = (ci + 1) % 4;
            end
            tick(r, a, kv, kd);
        end
        idle(3, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
